// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch/decode front end.
// Holds the RV32I opcode constants, the NOP word placed in an empty
// instruction register, the fetch-stage state encoding, the bit positions
// of the decode fields, and a helper that word-aligns a branch target.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // addi x0,x0,0
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQUISITA = 2'b00,
        CHEIO     = 2'b01,
        DESCARTA  = 2'b10
    } estado_t;

    localparam int OPCODE_MSB = 6;
    localparam int OPCODE_LSB = 0;
    localparam int RD_MSB     = 11;
    localparam int RD_LSB     = 7;
    localparam int F3_MSB     = 14;
    localparam int F3_LSB     = 12;
    localparam int RS1_MSB    = 19;
    localparam int RS1_LSB    = 15;
    localparam int RS2_MSB    = 24;
    localparam int RS2_LSB    = 20;
    localparam int F7_MSB     = 31;
    localparam int F7_LSB     = 25;

    // Instructions are word aligned; the low two address bits are dropped.
    function automatic logic [31:0] alinha(input logic [31:0] endereco);
        return endereco & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/estagio_busca_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
//   mem_requisicao : request from fetch stage
//   mem_endereco   : fetch address (held while the request is pending)
//   mem_pronto     : memory completes the request, mem_dado valid
//   mem_dado       : fetched instruction word
// master = fetch stage, slave = memory.
interface estagio_busca_if;
    logic        mem_requisicao;
    logic [31:0] mem_endereco;
    logic        mem_pronto;
    logic [31:0] mem_dado;

    modport master (output mem_requisicao, output mem_endereco,
                    input  mem_pronto,     input  mem_dado);
    modport slave  (input  mem_requisicao, input  mem_endereco,
                    output mem_pronto,     output mem_dado);
endinterface

// File: rtl/estagio_busca_contador_programa.sv
// Program counter register.
//   clk, rst      : clock, asynchronous active-high reset (loads PC_INICIAL)
//   i_carregar    : load i_valor (word aligned); has priority over increment
//   i_incrementar : advance by 4, modulo 2^32
//   o_pc          : current program counter
module contador_programa
    import riscv_pkg::*;
#(
    parameter logic [31:0] PC_INICIAL = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_carregar,
    input  logic        i_incrementar,
    input  logic [31:0] i_valor,
    output logic [31:0] o_pc
);

    logic [31:0] r_pc;

    // PC register: load beats increment, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= PC_INICIAL;
        end else if (i_carregar) begin
            r_pc <= alinha(i_valor);
        end else if (i_incrementar) begin
            r_pc <= r_pc + 32'd4;
        end else begin
            r_pc <= r_pc;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/estagio_busca.sv
// Instruction-fetch stage feeding the control unit.
//   clk, reset      : clock, asynchronous active-high reset
//   mem             : instruction-memory bus (master side)
//   consumir        : decode accepts instrucao this cycle
//   desvio_tomado   : single-cycle redirect strobe from execute
//   alvo_desvio     : redirect target
//   instrucao       : instruction register, pc_instrucao its address
//   instrucao_valida: instrucao is valid for decode
//   codigo_operacao, funcao3, funcao7, rd, rs1, rs2 : decode field slices
// One request outstanding at a time; no prefetch while an instruction is held.
module estagio_busca
    import riscv_pkg::*;
#(
    parameter logic [31:0] PC_INICIAL = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    estagio_busca_if.master mem,
    input  logic            consumir,
    input  logic            desvio_tomado,
    input  logic [31:0]     alvo_desvio,
    output logic [31:0]     instrucao,
    output logic [31:0]     pc_instrucao,
    output logic            instrucao_valida,
    output logic [6:0]      codigo_operacao,
    output logic [2:0]      funcao3,
    output logic [6:0]      funcao7,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2
);

    estado_t     r_estado;
    estado_t     w_prox_estado;
    logic [31:0] r_alvo_pendente;
    logic [31:0] w_alvo_pendente_prox;
    logic [31:0] r_instrucao;
    logic [31:0] r_pc_instrucao;
    logic        r_instrucao_valida;
    logic [31:0] w_pc;
    logic        w_carregar;
    logic        w_incrementar;
    logic [31:0] w_valor_carga;
    logic        w_captura;
    logic        w_anula;
    logic        w_consome;

    contador_programa #(.PC_INICIAL(PC_INICIAL)) u_pc (
        .clk           (clk),
        .rst           (reset),
        .i_carregar    (w_carregar),
        .i_incrementar (w_incrementar),
        .i_valor       (w_valor_carga),
        .o_pc          (w_pc)
    );

    // Next-state and datapath control decode.
    always_comb begin
        w_prox_estado        = r_estado;
        w_carregar           = 1'b0;
        w_incrementar        = 1'b0;
        w_valor_carga        = alvo_desvio;
        w_alvo_pendente_prox = r_alvo_pendente;
        w_captura            = 1'b0;
        w_anula              = 1'b0;
        w_consome            = 1'b0;
        case (r_estado)
            REQUISITA: begin
                if (mem.mem_pronto && !desvio_tomado) begin
                    w_captura     = 1'b1;
                    w_incrementar = 1'b1;
                    w_prox_estado = CHEIO;
                end else if (mem.mem_pronto) begin
                    // Returned word belongs to the wrong path: drop it.
                    w_carregar = 1'b1;
                end else if (desvio_tomado) begin
                    w_alvo_pendente_prox = alvo_desvio;
                    w_prox_estado        = DESCARTA;
                end else begin
                    w_prox_estado = REQUISITA;
                end
            end
            DESCARTA: begin
                // The old request must complete before the address may move.
                if (mem.mem_pronto) begin
                    w_carregar    = 1'b1;
                    w_valor_carga = desvio_tomado ? alvo_desvio : r_alvo_pendente;
                    w_prox_estado = REQUISITA;
                end else if (desvio_tomado) begin
                    w_alvo_pendente_prox = alvo_desvio;
                end else begin
                    w_prox_estado = DESCARTA;
                end
            end
            CHEIO: begin
                if (desvio_tomado) begin
                    w_anula       = 1'b1;
                    w_carregar    = 1'b1;
                    w_prox_estado = REQUISITA;
                end else if (consumir) begin
                    w_consome     = 1'b1;
                    w_prox_estado = REQUISITA;
                end else begin
                    w_prox_estado = CHEIO;
                end
            end
            default: begin
                w_prox_estado = REQUISITA;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_estado <= REQUISITA;
        end else begin
            r_estado <= w_prox_estado;
        end
    end

    // Pending redirect target captured while a request is in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_alvo_pendente <= 32'h0000_0000;
        end else begin
            r_alvo_pendente <= w_alvo_pendente_prox;
        end
    end

    // Instruction register, its PC and the valid flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instrucao        <= INSTR_NOP;
            r_pc_instrucao     <= 32'h0000_0000;
            r_instrucao_valida <= 1'b0;
        end else if (w_captura) begin
            r_instrucao        <= mem.mem_dado;
            r_pc_instrucao     <= w_pc;
            r_instrucao_valida <= 1'b1;
        end else if (w_anula) begin
            r_instrucao        <= INSTR_NOP;
            r_instrucao_valida <= 1'b0;
        end else if (w_consome) begin
            r_instrucao_valida <= 1'b0;
        end else begin
            r_instrucao_valida <= r_instrucao_valida;
        end
    end

    // No request while reset is held, even though the state reads REQUISITA.
    assign mem.mem_requisicao = !reset && (r_estado != CHEIO);
    assign mem.mem_endereco   = w_pc;

    assign instrucao        = r_instrucao;
    assign pc_instrucao     = r_pc_instrucao;
    assign instrucao_valida = r_instrucao_valida;
    assign codigo_operacao  = r_instrucao[OPCODE_MSB:OPCODE_LSB];
    assign funcao3          = r_instrucao[F3_MSB:F3_LSB];
    assign funcao7          = r_instrucao[F7_MSB:F7_LSB];
    assign rd               = r_instrucao[RD_MSB:RD_LSB];
    assign rs1              = r_instrucao[RS1_MSB:RS1_LSB];
    assign rs2              = r_instrucao[RS2_MSB:RS2_LSB];

endmodule
